state_sequencer: RTL and testbench

STATE_SEQUENCER -- requirements
Module: state_sequencer

---
 rtl/state_sequencer_pkg.sv | 37 +++
 rtl/state_sequencer_sat_counter16.sv | 29 ++
 rtl/state_sequencer.sv | 124 ++++++++++++
 tb/tb_state_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/state_sequencer_pkg.sv
// Shared state definitions for the control sequencer and the instruction decoder:
// 12-bit state codes, opcode constants and the counter saturation limit.
package state_sequencer_pkg;

   typedef enum logic [11:0] {
      ST_R    = 12'h001,
      ST_F0   = 12'h002,
      ST_F1   = 12'h004,
      ST_F2   = 12'h008,
      ST_DEC  = 12'h010,
      ST_MOV0 = 12'h020,
      ST_LD0  = 12'h100,
      ST_LD1  = 12'h101,
      ST_LD2  = 12'h102,
      ST_LD3  = 12'h103,
      ST_LD4  = 12'h104,
      ST_ST0  = 12'h200,
      ST_ST1  = 12'h201,
      ST_ST2  = 12'h202,
      ST_ST3  = 12'h203,
      ST_ST4  = 12'h204,
      ST_HALT = 12'h800
   } state_t;

   localparam logic [3:0]  OP_MOV  = 4'h1;
   localparam logic [3:0]  OP_LD   = 4'h2;
   localparam logic [3:0]  OP_ST   = 4'h3;
   localparam logic [3:0]  OP_HALT = 4'hF;

   localparam logic [15:0] SAT_MAX = 16'hFFFF;

   // Terminal micro-steps must be closed by end_sq; reaching them without it is an error.
   function automatic logic is_terminal(state_t s);
      return (s == ST_MOV0) || (s == ST_LD4) || (s == ST_ST4);
   endfunction

endpackage

// File: rtl/state_sequencer_sat_counter16.sv
// sat_counter16: 16-bit event counter with synchronous clear that sticks at SAT_MAX.
module sat_counter16
   import state_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        clr_i,
   input  logic        en_i,
   output logic [15:0] count_o
);

   logic [15:0] count_q;
   logic [15:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = 16'h0000;
      end else if (en_i && (count_q != SAT_MAX)) begin
         count_d = count_q + 16'h0001;
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/state_sequencer.sv
// Micro-sequencer: fetch/decode/execute control states, sticky error flag and
// saturating cycle/instruction counters. Optional single-step input: STATE_SEQUENCER_STEP_EN.
module state_sequencer
   import state_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  I,
   input  logic        end_sq,
   input  logic        pause_cc,
   input  logic        run,
`ifdef STATE_SEQUENCER_STEP_EN
   input  logic        step,
`endif
   output logic [11:0] state,
   output logic        halted,
   output logic        err,
   output logic [15:0] cycles,
   output logic [15:0] instrs
);

   state_t     state_q, state_d;
   logic       err_q, err_d;
   logic       go;
   logic       advance;
   logic [3:0] opcode;
   logic       unused_ir;

   assign opcode    = I[7:4];
   assign unused_ir = ^I[3:0];

`ifdef STATE_SEQUENCER_STEP_EN
   logic step_q;

   // The step edge is consumed every cycle, even when pause_cc blocks the advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         step_q <= 1'b0;
      end else begin
         step_q <= step;
      end
   end

   assign go = run | (step & ~step_q);
`else
   assign go = run;
`endif

   assign advance = (state_q != ST_HALT) & ~pause_cc & go;

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      if (advance) begin
         if (end_sq) begin
            state_d = ST_F0;
         end else begin
            case (state_q)
               ST_R:    state_d = ST_F0;
               ST_F0:   state_d = ST_F1;
               ST_F1:   state_d = ST_F2;
               ST_F2:   state_d = ST_DEC;
               ST_DEC: begin
                  case (opcode)
                     OP_MOV:  state_d = ST_MOV0;
                     OP_LD:   state_d = ST_LD0;
                     OP_ST:   state_d = ST_ST0;
                     OP_HALT: state_d = ST_HALT;
                     default: begin
                        state_d = ST_F0;
                        err_d   = 1'b1;
                     end
                  endcase
               end
               ST_LD0:  state_d = ST_LD1;
               ST_LD1:  state_d = ST_LD2;
               ST_LD2:  state_d = ST_LD3;
               ST_LD3:  state_d = ST_LD4;
               ST_ST0:  state_d = ST_ST1;
               ST_ST1:  state_d = ST_ST2;
               ST_ST2:  state_d = ST_ST3;
               ST_ST3:  state_d = ST_ST4;
               default: begin
                  // Unclosed terminal steps and corrupted codes both recover via F0.
                  state_d = ST_F0;
                  err_d   = 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_R;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   sat_counter16 u_cycles (
      .clk     (clk),
      .clr_i   (reset),
      .en_i    (advance),
      .count_o (cycles)
   );

   sat_counter16 u_instrs (
      .clk     (clk),
      .clr_i   (reset),
      .en_i    (advance & end_sq),
      .count_o (instrs)
   );

   assign state  = state_q;
   assign halted = (state_q == ST_HALT);
   assign err    = err_q;

   logic unused_term;
   assign unused_term = is_terminal(state_q);

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer: a class/step model checked every cycle,
// plus literal expectations for the main scenarios.
module tb_state_sequencer;
   import state_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset, end_sq, pause_cc, run, step;
   logic [7:0]  I;
   logic [11:0] state;
   logic        halted, err;
   logic [15:0] cycles, instrs;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   state_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .I        (I),
      .end_sq   (end_sq),
      .pause_cc (pause_cc),
      .run      (run),
`ifdef STATE_SEQUENCER_STEP_EN
      .step     (step),
`endif
      .state    (state),
      .halted   (halted),
      .err      (err),
      .cycles   (cycles),
      .instrs   (instrs)
   );

   // Model: instruction class plus micro-step index within that class.
   localparam logic [3:0] C_R = 0, C_F = 1, C_D = 2, C_M = 3, C_L = 4, C_S = 5, C_H = 6;

   typedef struct packed {
      logic [3:0] cls;
      logic [3:0] idx;
      logic       err;
   } mst_t;

   mst_t        m;
   logic [15:0] m_cyc, m_ins;
   logic        m_stp;
   bit          m_valid = 1'b0;

   function automatic logic [11:0] code_of(mst_t s);
      case (s.cls)
         C_R: return ST_R;
         C_F: return (s.idx == 0) ? ST_F0 : (s.idx == 1) ? ST_F1 : ST_F2;
         C_D: return ST_DEC;
         C_M: return ST_MOV0;
         C_L: case (s.idx)
                 0: return ST_LD0; 1: return ST_LD1; 2: return ST_LD2;
                 3: return ST_LD3; default: return ST_LD4;
              endcase
         C_S: case (s.idx)
                 0: return ST_ST0; 1: return ST_ST1; 2: return ST_ST2;
                 3: return ST_ST3; default: return ST_ST4;
              endcase
         default: return ST_HALT;
      endcase
   endfunction

   function automatic int seq_len(logic [3:0] cls);
      return (cls == C_F) ? 3 : (cls == C_M) ? 1 : 5;
   endfunction

   function automatic mst_t model_next(mst_t s, logic [7:0] ir, logic es);
      mst_t n = s;
      n.idx = 0;
      if (es) begin
         n.cls = C_F;
      end else if (s.cls == C_R) begin
         n.cls = C_F;
      end else if (s.cls == C_D) begin
         case (ir[7:4])
            OP_MOV:  n.cls = C_M;
            OP_LD:   n.cls = C_L;
            OP_ST:   n.cls = C_S;
            OP_HALT: n.cls = C_H;
            default: begin n.cls = C_F; n.err = 1'b1; end
         endcase
      end else if (32'(s.idx) + 1 < seq_len(s.cls)) begin
         n.idx = s.idx + 1;
      end else if (s.cls == C_F) begin
         n.cls = C_D;
      end else begin
         n.cls = C_F;
         n.err = 1'b1;
      end
      return n;
   endfunction

   function automatic logic model_go(logic r, logic st, logic st_prev);
`ifdef STATE_SEQUENCER_STEP_EN
      return r || (st && !st_prev);
`else
      return r || (st && st_prev && 1'b0);
`endif
   endfunction

   function automatic logic [15:0] sat_inc(logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m       <= '{cls: C_R, idx: 4'd0, err: 1'b0};
         m_cyc   <= 16'd0;
         m_ins   <= 16'd0;
         m_stp   <= 1'b0;
         m_valid <= 1'b1;
      end else begin
         if (m.cls != C_H && !pause_cc && model_go(run, step, m_stp)) begin
            m     <= model_next(m, I, end_sq);
            m_cyc <= sat_inc(m_cyc);
            if (end_sq) m_ins <= sat_inc(m_ins);
         end
         m_stp <= step;
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_state",  {4'h0, state}, {4'h0, code_of(m)});
         chk("m_halted", {15'd0, halted}, {15'd0, m.cls == C_H});
         chk("m_err",    {15'd0, err}, {15'd0, m.err});
         chk("m_cycles", cycles, m_cyc);
         chk("m_instrs", instrs, m_ins);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string name, input logic [11:0] exp);
      tick();
      chk(name, {4'h0, state}, {4'h0, exp});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [15:0] held;
      bit          found;
      reset = 1'b1; I = 8'h16; end_sq = 1'b0; pause_cc = 1'b0; run = 1'b1; step = 1'b0;
      tick();
      tick();
      chk("rst_state", {4'h0, state}, {4'h0, ST_R});
      chk("rst_cycles", cycles, 16'd0);
      reset = 1'b0;

      // MOV
      expect_state("mov_f0", ST_F0);
      expect_state("mov_f1", ST_F1);
      expect_state("mov_f2", ST_F2);
      expect_state("mov_dec", ST_DEC);
      expect_state("mov_mov0", ST_MOV0);
      end_sq = 1'b1;
      expect_state("mov_end", ST_F0);
      end_sq = 1'b0;
      chk("mov_cycles", cycles, 16'd6);
      chk("mov_instrs", instrs, 16'd1);
      $display("MOV done: cycles=%0d instrs=%0d", cycles, instrs);

      // LD
      I = 8'h21;
      expect_state("ld_f1", ST_F1);
      expect_state("ld_f2", ST_F2);
      expect_state("ld_dec", ST_DEC);
      expect_state("ld_0", ST_LD0);
      expect_state("ld_1", ST_LD1);
      expect_state("ld_2", ST_LD2);
      expect_state("ld_3", ST_LD3);
      expect_state("ld_4", ST_LD4);
      end_sq = 1'b1;
      expect_state("ld_end", ST_F0);
      end_sq = 1'b0;
      chk("ld_err", {15'd0, err}, 16'd0);
      chk("ld_cycles", cycles, 16'd15);
      $display("LD done: cycles=%0d instrs=%0d", cycles, instrs);

      // ST with pause in ST2
      I = 8'h31;
      for (int k = 0; k < 6; k++) tick();
      chk("st_at_st2", {4'h0, state}, {4'h0, ST_ST2});
      pause_cc = 1'b1;
      for (int k = 0; k < 3; k++) begin
         expect_state("pause_hold", ST_ST2);
         chk("pause_cycles", cycles, 16'd21);
      end
      pause_cc = 1'b0;
      expect_state("st_3", ST_ST3);
      expect_state("st_4", ST_ST4);
      end_sq = 1'b1;
      expect_state("st_end", ST_F0);
      end_sq = 1'b0;
      chk("st_instrs", instrs, 16'd3);
      $display("ST done: cycles=%0d instrs=%0d", cycles, instrs);

      // HALT and hold
      I = 8'hF0;
      for (int k = 0; k < 4; k++) tick();
      chk("halt_state", {4'h0, state}, {4'h0, ST_HALT});
      chk("halt_flag", {15'd0, halted}, 16'd1);
      for (int k = 0; k < 100; k++) begin
         run = 1'($urandom_range(0, 1)); end_sq = 1'($urandom_range(0, 1));
         pause_cc = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
         tick();
      end
      run = 1'b1; end_sq = 1'b0; pause_cc = 1'b0; step = 1'b0;
      chk("halt_held", {4'h0, state}, {4'h0, ST_HALT});
      chk("halt_cycles", cycles, 16'd28);
      do_reset();
      chk("hrst_state", {4'h0, state}, {4'h0, ST_R});
      chk("hrst_cycles", cycles, 16'd0);
      chk("hrst_instrs", instrs, 16'd0);
      chk("hrst_halted", {15'd0, halted}, 16'd0);
      $display("HALT done: reset from HALT gives state=%h", state);

      // Illegal opcode
      I = 8'h70;
      for (int k = 0; k < 4; k++) tick();
      chk("ill_dec", {4'h0, state}, {4'h0, ST_DEC});
      expect_state("ill_f0", ST_F0);
      chk("ill_err", {15'd0, err}, 16'd1);
      $display("Illegal opcode done: err=%0d", err);

      // MOV0 without end_sq
      do_reset();
      chk("rst_err", {15'd0, err}, 16'd0);
      I = 8'h16;
      for (int k = 0; k < 5; k++) tick();
      chk("term_mov0", {4'h0, state}, {4'h0, ST_MOV0});
      expect_state("term_f0", ST_F0);
      chk("term_err", {15'd0, err}, 16'd1);
      $display("Unclosed terminal done: err=%0d", err);

      // Run freeze and single step
      do_reset();
      I = 8'h21;
      tick();
      tick();
      run = 1'b0;
      for (int k = 0; k < 5; k++) expect_state("freeze", ST_F1);
`ifdef STATE_SEQUENCER_STEP_EN
      step = 1'b1; expect_state("step1", ST_F2);  step = 1'b0; tick();
      step = 1'b1; expect_state("step2", ST_DEC); step = 1'b0; tick();
      step = 1'b1; expect_state("step3", ST_LD0); step = 1'b0; tick();
      step = 1'b1;
      for (int k = 0; k < 4; k++) expect_state("step_held", ST_LD1);
      step = 1'b0; tick();
      pause_cc = 1'b1; step = 1'b1;
      expect_state("step_paused", ST_LD1);
      pause_cc = 1'b0;
      expect_state("step_consumed", ST_LD1);
      step = 1'b0;
`endif
      run = 1'b1;
      $display("Run/step done: state=%h", state);

      // Saturation
      do_reset();
      I = 8'h16;
      for (int k = 0; k < 65540; k++) begin
         end_sq = (m.cls == C_M);
         tick();
      end
      chk("sat_cycles", cycles, 16'hFFFF);
      for (int k = 0; k < 3; k++) begin
         end_sq = (m.cls == C_M);
         tick();
      end
      chk("sat_stays", cycles, 16'hFFFF);
      I = 8'h21;
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         end_sq = (m.cls == C_M) || (m.cls == C_L && m.idx == 4);
         tick();
         found = (m.cls == C_L && m.idx == 3);
      end
      end_sq = 1'b0;
      chk("reach_ld3", {15'd0, found}, 16'd1);
      chk("sat_ld3", {4'h0, state}, {4'h0, ST_LD3});
      held = cycles;
      do_reset();
      chk("ld3_rst", {4'h0, state}, {4'h0, ST_R});
      chk("ld3_rst_cyc", cycles, 16'd0);
      $display("Saturation done: cycles before reset=%h", held);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
